// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with sticky C/V/N/Z flags.
// Single-step ops finish in the cycle after START; shifts and the
// shift-add multiply iterate one step per clock while BUSY is high.
//
// state | meaning
// IDLE  | waiting for START; single-step ops complete from here
// RUN   | iterating a shift or multiply, counter holds steps left
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             use_carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [WIDTH:0] W_EXT    = (WIDTH + 1)'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic                 c_q, c_d;
    logic                 v_q, v_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 big_q, big_d;
    logic                 cbig_q, cbig_d;

    logic [WIDTH-1:0]     addend;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic                 big;
    logic                 sout;
    logic [WIDTH:0]       mul_sum;

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, single-step results and one iteration step per RUN cycle.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        big_d   = big_q;
        cbig_d  = cbig_q;
        sout    = 1'b0;
        mul_sum = '0;

        // SUB is A + ~B + cin, so the default carry-in for SUB is 1.
        addend = (op == OP_SUB) ? ~b : b;
        cin    = use_carry ? c_q : (op == OP_SUB);
        sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
        big    = ({1'b0, b} >= W_EXT);

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            y_d    = sum[WIDTH-1:0];
                            c_d    = sum[WIDTH];
                            v_d    = (a[WIDTH-1] == addend[WIDTH-1]) &&
                                     (sum[WIDTH-1] != a[WIDTH-1]);
                            done_d = 1'b1;
                        end
                        OP_AND: begin
                            y_d    = a & b;
                            c_d    = 1'b0;
                            v_d    = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_OR: begin
                            y_d    = a | b;
                            c_d    = 1'b0;
                            v_d    = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_XOR: begin
                            y_d    = a ^ b;
                            c_d    = 1'b0;
                            v_d    = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (b == '0) begin
                                y_d    = a;
                                c_d    = 1'b0;
                                v_d    = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                // Oversized shifts run WIDTH steps; their carry is
                                // the first bit out, captured here up front.
                                state_d = RUN;
                                op_d    = op;
                                sh_d    = a;
                                big_d   = big;
                                cbig_d  = (op == OP_SHR) ? a[0] : a[WIDTH-1];
                                cnt_d   = big ? CNT_FULL : b[CW-1:0];
                            end
                        end
                        default: begin
                            state_d = RUN;
                            op_d    = op;
                            mcand_d = a;
                            acc_d   = {{WIDTH{1'b0}}, b};
                            cnt_d   = CNT_FULL;
                        end
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    // Multiplier sits in the low half and shifts out LSB first.
                    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                              (acc_q[0] ? {1'b0, mcand_q} : '0);
                    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                end else if (op_q == OP_SHL) begin
                    sout = sh_q[WIDTH-1];
                    sh_d = {sh_q[WIDTH-2:0], 1'b0};
                end else begin
                    sout = sh_q[0];
                    sh_d = {1'b0, sh_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (op_q == OP_MUL) begin
                        y_d = acc_d[WIDTH-1:0];
                        c_d = |acc_d[2*WIDTH-1:WIDTH];
                        v_d = |acc_d[2*WIDTH-1:WIDTH];
                    end else begin
                        y_d = sh_d;
                        c_d = big_q ? cbig_q : sout;
                        v_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result, flag and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            sh_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            big_q   <= 1'b0;
            cbig_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            big_q   <= big_d;
            cbig_q  <= cbig_d;
        end
    end

    assign y    = y_q;
    assign c    = c_q;
    assign v    = v_q;
    assign n    = y_q[WIDTH-1];
    assign z    = ~|y_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [2:0]  op;
    logic        use_carry;
    logic [15:0] a, b;

    logic [7:0]  y8;
    logic        c8, v8, n8, z8, busy8, done8;
    logic [15:0] y16;
    logic        c16, v16, n16, z16, busy16, done16;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .use_carry(use_carry),
        .a(a[7:0]), .b(b[7:0]), .y(y8), .c(c8), .v(v8), .n(n8), .z(z8),
        .busy(busy8), .done(done8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op), .use_carry(use_carry),
        .a(a), .b(b), .y(y16), .c(c16), .v(v16), .n(n16), .z(z16),
        .busy(busy16), .done(done16)
    );

    typedef struct {
        int          issue;
        int          exp_cyc;
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sel16 = 1'b0;
    bit   running = 1'b0;
    bit   cm8 = 1'b0;
    bit   cm16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference behaviour: result, flags and cycles from START to DONE.
    function automatic void model(input int w, input logic [2:0] o, input int av, input int bv,
                                  input bit ucv, input bit cm, output int yv, output bit cv,
                                  output bit vv, output int lat);
        int     mask;
        int     bb;
        int     s;
        longint p;
        mask = (1 << w) - 1;
        lat  = 1;
        cv   = 1'b0;
        vv   = 1'b0;
        yv   = 0;
        case (o)
            3'd0, 3'd1: begin
                bb = (o == 3'd1) ? (~bv & mask) : bv;
                s  = av + bb + (ucv ? int'(cm) : ((o == 3'd1) ? 1 : 0));
                yv = s & mask;
                cv = ((s >> w) & 1) != 0;
                vv = (((av >> (w - 1)) & 1) == ((bb >> (w - 1)) & 1)) &&
                     (((yv >> (w - 1)) & 1) != ((av >> (w - 1)) & 1));
            end
            3'd2: begin
                if (bv == 0) yv = av;
                else if (bv >= w) begin
                    yv = 0; cv = ((av >> (w - 1)) & 1) != 0; lat = w + 1;
                end else begin
                    yv = (av << bv) & mask; cv = ((av >> (w - bv)) & 1) != 0; lat = bv + 1;
                end
            end
            3'd3: begin
                if (bv == 0) yv = av;
                else if (bv >= w) begin
                    yv = 0; cv = (av & 1) != 0; lat = w + 1;
                end else begin
                    yv = av >> bv; cv = ((av >> (bv - 1)) & 1) != 0; lat = bv + 1;
                end
            end
            3'd4: yv = av & bv;
            3'd5: yv = av | bv;
            3'd6: yv = av ^ bv;
            default: begin
                p   = longint'(av) * longint'(bv);
                yv  = int'(p & longint'(mask));
                vv  = (p >> w) != 0;
                cv  = vv;
                lat = w + 1;
            end
        endcase
    endfunction

    function automatic exp_t mk_exp(input int w, input int t, input int lat, input int yv,
                                    input bit cv, input bit vv);
        exp_t e;
        e.issue   = t;
        e.exp_cyc = t + lat;
        e.y       = 16'(yv);
        e.c       = cv;
        e.v       = vv;
        e.n       = ((yv >> (w - 1)) & 1) != 0;
        e.z       = (yv == 0);
        return e;
    endfunction

    // Per-cycle monitor: BUSY window against the head entry, results on DONE.
    always @(negedge clk) begin
        logic [15:0] yo;
        logic        co, vo, no, zo, bo, dn, eb;
        exp_t        e;
        if (running && !rst) begin
            yo = sel16 ? y16 : {8'h00, y8};
            co = sel16 ? c16 : c8;
            vo = sel16 ? v16 : v8;
            no = sel16 ? n16 : n8;
            zo = sel16 ? z16 : z8;
            bo = sel16 ? busy16 : busy8;
            dn = sel16 ? done16 : done8;
            eb = (sb.size() > 0) && (cyc > sb[0].issue) && (cyc < sb[0].exp_cyc);
            check("busy", 32'(bo), 32'(eb));
            if (dn) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(dn), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.exp_cyc);
                    check("y", 32'(yo), 32'(e.y));
                    check("c", 32'(co), 32'(e.c));
                    check("v", 32'(vo), 32'(e.v));
                    check("n", 32'(no), 32'(e.n));
                    check("z", 32'(zo), 32'(e.z));
                end
            end
        end
    end

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic issue(input bit s16, input logic [2:0] o, input int av_in, input int bv_in,
                         input bit ucv);
        int w, av, bv, yv, lat;
        bit cv, vv;
        w  = s16 ? 16 : 8;
        av = av_in & ((1 << w) - 1);
        bv = bv_in & ((1 << w) - 1);
        model(w, o, av, bv, ucv, s16 ? cm16 : cm8, yv, cv, vv, lat);
        @(posedge clk); #1;
        sel16     = s16;
        op        = o;
        a         = 16'(av);
        b         = 16'(bv);
        use_carry = ucv;
        if (s16) start16 = 1'b1; else start8 = 1'b1;
        sb.push_back(mk_exp(w, cyc, lat, yv, cv, vv));
        if (s16) cm16 = cv; else cm8 = cv;
        @(posedge clk); #1;
        start8  = 1'b0;
        start16 = 1'b0;
        wait_empty(lat + 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t, yv, lat;
        bit   cv, vv;
        logic [2:0] ro;

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        op = 3'd0; use_carry = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", 32'(y8), 32'd0);
        check("rst_c", 32'(c8), 32'd0);
        check("rst_v", 32'(v8), 32'd0);
        check("rst_n", 32'(n8), 32'd0);
        check("rst_z", 32'(z8), 32'd1);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_z16", 32'(z16), 32'd1);
        rst = 1'b0;
        running = 1'b1;

        // Add / subtract with and without chained carry.
        issue(0, 3'd0, 'h7F, 'h01, 0);
        issue(0, 3'd0, 'hFF, 'h01, 0);
        issue(0, 3'd0, 'h00, 'h00, 1);
        issue(0, 3'd1, 'h05, 'h05, 0);
        issue(0, 3'd1, 'h00, 'h01, 0);
        issue(0, 3'd1, 'h80, 'h01, 0);
        issue(0, 3'd1, 'h10, 'h01, 1);

        // Shifts: multi-step, zero amount, oversized.
        issue(0, 3'd2, 'h81, 3, 0);
        issue(0, 3'd3, 'h81, 0, 0);
        issue(0, 3'd3, 'h81, 9, 0);
        issue(0, 3'd2, 'h01, 8, 0);
        issue(0, 3'd3, 'h80, 8, 0);
        issue(0, 3'd3, 'hC4, 3, 1);

        // Bitwise ignore the stored carry.
        issue(0, 3'd4, 'hF0, 'h3C, 1);
        issue(0, 3'd5, 'hF0, 'h0C, 1);
        issue(0, 3'd6, 'hFF, 'hFF, 1);

        // Multiply.
        issue(0, 3'd7, 'h10, 'h10, 0);
        issue(0, 3'd7, 'h0F, 'h03, 0);

        // Reset in RUN cycle 3 of a multiply.
        @(posedge clk); #1;
        sel16 = 1'b0; op = 3'd7; a = 16'h0012; b = 16'h0034; use_carry = 1'b0;
        start8 = 1'b1;
        model(8, 3'd7, 'h12, 'h34, 0, cm8, yv, cv, vv, lat);
        sb.push_back(mk_exp(8, cyc, lat, yv, cv, vv));
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        cm8 = 1'b0;
        cm16 = 1'b0;
        #1;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_y", 32'(y8), 32'd0);
        check("midrst_z", 32'(z8), 32'd1);
        check("midrst_done", 32'(done8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        issue(0, 3'd0, 1, 1, 0);

        // START held high through repeated multiplies.
        @(posedge clk); #1;
        sel16 = 1'b0; op = 3'd7; a = 16'h000F; b = 16'h0003; use_carry = 1'b0;
        start8 = 1'b1;
        t = cyc;
        model(8, 3'd7, 'h0F, 'h03, 0, cm8, yv, cv, vv, lat);
        for (int k = 0; k < 3; k++) sb.push_back(mk_exp(8, t + 9 * k, lat, yv, cv, vv));
        cm8 = cv;
        repeat (19) @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_empty(40);
        repeat (12) @(posedge clk);

        // Random mix at WIDTH=8.
        for (int i = 0; i < 20; i++) begin
            ro = 3'($urandom_range(0, 7));
            issue(0, ro, int'($urandom_range(0, 255)),
                  (ro == 3'd2 || ro == 3'd3) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        // WIDTH=16.
        issue(1, 3'd7, 'h0100, 'h0100, 0);
        issue(1, 3'd0, 'hFFFF, 'h0001, 0);
        issue(1, 3'd0, 'h1234, 'h0000, 1);
        issue(1, 3'd2, 'h8001, 17, 0);
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            issue(1, ro, int'($urandom_range(0, 65535)),
                  (ro == 3'd2 || ro == 3'd3) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, handshaked successor to the 8-bit combinational ALU.
- Accepts an operation on a START pulse and returns a registered result with sticky C/V/N/Z flags.
- Adds carry-chained add/subtract, multi-bit shifts and an iterative shift-add multiply.
- Sits between the register file and the writeback mux; the controller waits on DONE.

Parameters:
WIDTH, 8, operand/result width in bits; legal values ≥ 2.

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
START  input  1  request; sampled only in IDLE
OP  input  3  0 ADD, 1 SUB, 2 SHL, 3 SHR (logical), 4 AND, 5 OR, 6 XOR, 7 MUL
USE_CARRY  input  1  ADD/SUB take carry-in from the stored C flag
A  input  WIDTH  operand A
B  input  WIDTH  operand B; shift amount for SHL/SHR
Y  output  WIDTH  registered result
C  output  1  registered carry flag
V  output  1  registered overflow flag
N  output  1  registered negative flag, equals Y[WIDTH-1]
Z  output  1  registered zero flag, high when Y is all zeros
BUSY  output  1  high while RUN
DONE  output  1  one-cycle pulse: Y and flags newly updated

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State = IDLE.
  - Y = 0, C = 0, V = 0, N = 0, Z = 1, BUSY = 0, DONE = 0, counter = 0.
  - The in-flight operation is discarded.
- States:
  - IDLE to IDLE: START=1 with a single-step op. Result computed from the live inputs and registered at the same edge; DONE=1 the next cycle.
  - IDLE to RUN: START=1 with an iterative op of step count n ≥ 1. Latch A, B, OP and the carry-in; counter = n.
  - RUN to RUN: one step per edge, counter decrements.
  - RUN to IDLE: at the edge where the last step completes, Y/flags are registered; DONE=1 the following cycle.
  - START is ignored while in RUN.
- Latency (START sampled in cycle T):
  - Single-step ops: DONE in cycle T+1.
  - Iterative ops: BUSY in cycles T+1..T+n; DONE in cycle T+n+1.
  - START in the DONE cycle is accepted, giving back-to-back operation.
- Step counts:
  - Single-step: ADD, SUB, AND, OR, XOR, and SHL/SHR with B = 0.
  - SHL/SHR: n = min(B, WIDTH).
  - MUL: n = WIDTH.
- Outputs Y, C, V, N, Z hold their values between DONEs; they change only on the DONE-producing edge or on reset.
- ADD:
  - Y = A + B + cin, where cin = USE_CARRY ? C : 0.
  - C = carry out of bit WIDTH-1.
  - V = signed overflow: operand MSBs equal, result MSB differs.
- SUB:
  - Y = A + ~B + cin, where cin = USE_CARRY ? C : 1.
  - C = carry out, so C=1 means no borrow.
  - V = signed overflow of A − B.
- SHL/SHR:
  - One bit position per step, zero fill.
  - C = last bit shifted out; C = 0 when B = 0.
  - B ≥ WIDTH: Y = 0, n = WIDTH, C = original bit 0 (SHR) or bit WIDTH-1 (SHL).
  - V = 0.
- AND/OR/XOR: bitwise; C = 0, V = 0.
- MUL:
  - Unsigned shift-add over WIDTH steps into a 2·WIDTH accumulator.
  - Y = low WIDTH bits.
  - C = V = 1 if the upper WIDTH bits are nonzero, else 0.
- N and Z are always derived from the new Y.
- USE_CARRY is ignored for every op except ADD/SUB.

Test Plan:
- Reset mid-MUL (WIDTH=8), asserted in RUN cycle 3 → BUSY=0 and Y=0, Z=1 immediately (asynchronous); no DONE follows; next START ADD 1+1 → DONE at T+1, Y=2.
- WIDTH=8, ADD 0x7F+0x01 → Y=0x80, C=0, V=1, N=1, Z=0 at T+1. Then ADD 0xFF+0x01 → Y=0x00, C=1, Z=1. Then ADD USE_CARRY 0x00+0x00 → Y=0x01.
- SUB 0x05−0x05 → Y=0, C=1, Z=1. SUB 0x00−0x01 → Y=0xFF, C=0, N=1. SUB 0x80−0x01 → Y=0x7F, V=1.
- SHL 0x81 by 3 → BUSY cycles T+1..T+3, DONE at T+4, Y=0x08, C=0. SHR 0x81 by 0 → DONE at T+1, Y=0x81, C=0. SHR 0x81 by 9 → Y=0, C=1, DONE at T+9.
- MUL 0x10·0x10 → DONE at T+9, Y=0x00, C=V=1, Z=1. MUL 0x0F·0x03 → Y=0x2D, C=V=0.
- Protocol: START held high through a MUL → re-accepted in the DONE cycle, so DONEs are exactly 9 cycles apart with no DONE during BUSY. Repeat with WIDTH=16: MUL 0x0100·0x0100 → C=1, DONE at T+17.
